// File: rtl/label_ram_writer.sv
// Write-side front end for the label character RAM: turns a valid/ready ASCII stream into
// cursor-driven writes inside one label window. Optional macro LABEL_WR_VBLANK_EN gates writes to vblank.
module label_ram_writer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int BASE       = 0,
  parameter int LEN        = 8,
  parameter logic [DATA_WIDTH-1:0] FILL = DATA_WIDTH'(8'h20)
) (
  input  logic                  px_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  input  logic                  clear_req,
  input  logic                  vblank,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] cursor,
  output logic                  busy
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [ADDR_WIDTH-1:0] BaseA = ADDR_WIDTH'(BASE);
  localparam logic [ADDR_WIDTH-1:0] LastA = ADDR_WIDTH'(BASE + LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] OneA  = ADDR_WIDTH'(1);
  localparam logic [CW-1:0]         LenC  = CW'(LEN);
  localparam logic [CW-1:0]         OneC  = CW'(1);
  localparam logic [DATA_WIDTH-1:0] ChCr  = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] ChBs  = DATA_WIDTH'(8'h08);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state, stateNext;
  logic [ADDR_WIDTH-1:0]   cursorNext, clrPtr, sweepPtr, sweepPtrNext, addrNext;
  logic [CW-1:0]           clrLeft, sweepLeft, sweepLeftNext;
  logic [DATA_WIDTH-1:0]   dinNext;
  logic                    weNext, go, sweep, accept;

`ifdef LABEL_WR_VBLANK_EN
  assign go = vblank;
`else
  logic unusedVblank;
  assign unusedVblank = vblank;
  assign go = 1'b1;
`endif

  assign char_ready = (state == IDLE) && !clear_req && go;
  assign accept     = char_valid && char_ready;
  assign busy       = (state == CLEAR);

  // The request cycle already issues the first sweep write, so busy spans exactly the write cycles.
  assign sweepPtr  = (state == IDLE) ? BaseA : clrPtr;
  assign sweepLeft = (state == IDLE) ? LenC  : clrLeft;

  always_comb begin
    stateNext     = state;
    cursorNext    = cursor;
    sweepPtrNext  = clrPtr;
    sweepLeftNext = clrLeft;
    weNext        = 1'b0;
    addrNext      = '0;
    dinNext       = '0;
    sweep         = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear_req) begin
          stateNext = CLEAR;
          sweep     = 1'b1;
        end else if (accept) begin
          if (char_in == ChCr) begin
            cursorNext = BaseA;
          end else if (char_in == ChBs) begin
            if (cursor != BaseA) begin
              cursorNext = cursor - OneA;
              weNext     = 1'b1;
              addrNext   = cursor - OneA;
              dinNext    = FILL;
            end
          end else begin
            weNext     = 1'b1;
            addrNext   = cursor;
            dinNext    = char_in;
            cursorNext = (cursor == LastA) ? BaseA : cursor + OneA;
          end
        end
      end
      CLEAR: sweep = 1'b1;
      default: stateNext = IDLE;
    endcase

    if (sweep) begin
      if (sweepLeft == '0) begin
        stateNext  = IDLE;
        cursorNext = BaseA;
      end else if (go) begin
        weNext        = 1'b1;
        addrNext      = sweepPtr;
        dinNext       = FILL;
        sweepPtrNext  = sweepPtr + OneA;
        sweepLeftNext = sweepLeft - OneC;
      end else begin
        sweepPtrNext  = sweepPtr;
        sweepLeftNext = sweepLeft;
      end
    end
  end

  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cursor   <= BaseA;
      clrPtr   <= BaseA;
      clrLeft  <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      state    <= stateNext;
      cursor   <= cursorNext;
      clrPtr   <= sweepPtrNext;
      clrLeft  <= sweepLeftNext;
      ram_we   <= weNext;
      ram_addr <= addrNext;
      ram_din  <= dinNext;
    end
  end

endmodule

// File: tb/tb_label_ram_writer.sv
// Bench for label_ram_writer: three windows (8/15, 0/8, 0/6) share one stimulus stream and are
// checked every cycle against a queue-based model, plus directed literal expectations.
module tb_label_ram_writer;

  function automatic int baseOf(input int i);
    return (i == 0) ? 8 : 0;
  endfunction
  function automatic int lenOf(input int i);
    return (i == 0) ? 15 : ((i == 1) ? 8 : 6);
  endfunction

  logic       pxClk = 1'b0;
  logic       rst, charValid, clearReq, vblank;
  logic [7:0] charIn;
  logic       readyO [3];
  logic       ramWe  [3];
  logic       busyO  [3];
  logic [7:0] ramAddr[3];
  logic [7:0] ramDin [3];
  logic [7:0] curs   [3];

  int checks = 0;
  int errors = 0;

  always #5 pxClk = ~pxClk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    label_ram_writer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE(baseOf(g)), .LEN(lenOf(g)),
                       .FILL(8'h20)) u (
      .px_clk(pxClk), .rst(rst), .char_in(charIn), .char_valid(charValid),
      .char_ready(readyO[g]), .clear_req(clearReq), .vblank(vblank),
      .ram_addr(ramAddr[g]), .ram_din(ramDin[g]), .ram_we(ramWe[g]),
      .cursor(curs[g]), .busy(busyO[g]));
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h want %0h", nm, d, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         mCur  [3];
  bit         mSweep[3];
  int         sweepQ[3][$];
  logic       eWe   [3];
  logic [7:0] eAddr [3];
  logic [7:0] eDin  [3];
  logic [15:0] wlog [3][$];

  function automatic bit goNow();
`ifdef LABEL_WR_VBLANK_EN
    return vblank;
`else
    return 1'b1;
`endif
  endfunction

  task automatic mReset();
    for (int d = 0; d < 3; d++) begin
      mCur[d] = baseOf(d); mSweep[d] = 0; sweepQ[d].delete();
      eWe[d] = 0; eAddr[d] = 0; eDin[d] = 0;
    end
  endtask

  task automatic mWrite(input int d, input int a, input logic [7:0] v);
    eWe[d] = 1; eAddr[d] = 8'(a); eDin[d] = v;
  endtask

  task automatic mStep(input int d);
    int b, l;
    b = baseOf(d); l = lenOf(d);
    eWe[d] = 0; eAddr[d] = 0; eDin[d] = 0;
    if (mSweep[d]) begin
      if (sweepQ[d].size() == 0) begin
        mSweep[d] = 0; mCur[d] = b;
      end else if (goNow()) mWrite(d, sweepQ[d].pop_front(), 8'h20);
    end else if (clearReq) begin
      mSweep[d] = 1;
      for (int i = 0; i < l; i++) sweepQ[d].push_back(b + i);
      if (goNow()) mWrite(d, sweepQ[d].pop_front(), 8'h20);
    end else if (charValid && goNow()) begin
      if (charIn == 8'h0D) mCur[d] = b;
      else if (charIn == 8'h08) begin
        if (mCur[d] != b) begin
          mCur[d]--; mWrite(d, mCur[d], 8'h20);
        end
      end else begin
        mWrite(d, mCur[d], charIn);
        mCur[d] = b + ((mCur[d] - b + 1) % l);
      end
    end
  endtask

  initial begin
    mReset();
    forever begin
      @(posedge pxClk or posedge rst);
      if (rst) mReset();
      else for (int d = 0; d < 3; d++) mStep(d);
    end
  end

  // Every-cycle comparison plus write logging for the directed checks.
  initial begin
    forever begin
      @(negedge pxClk);
      for (int d = 0; d < 3; d++) begin
        chk("we", d, 32'(ramWe[d]), 32'(eWe[d]));
        chk("addr", d, 32'(ramAddr[d]), 32'(eAddr[d]));
        chk("din", d, 32'(ramDin[d]), 32'(eDin[d]));
        chk("cursor", d, 32'(curs[d]), 32'(mCur[d][7:0]));
        chk("busy", d, 32'(busyO[d]), 32'(mSweep[d]));
        chk("ready", d, 32'(readyO[d]), 32'(!mSweep[d] && !clearReq && goNow()));
        if (ramWe[d]) wlog[d].push_back({ramAddr[d], ramDin[d]});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge pxClk); #2;
  endtask

  task automatic sendChar(input logic [7:0] c);
    charIn = c; charValid = 1'b1;
    @(posedge pxClk); #2;
    charValid = 1'b0;
  endtask

  task automatic pulseClear();
    clearReq = 1'b1;
    @(posedge pxClk); #2;
    clearReq = 1'b0;
  endtask

  task automatic flush();
    for (int d = 0; d < 3; d++) wlog[d].delete();
  endtask

  task automatic expWrite(input int d, input logic [7:0] a, input logic [7:0] v);
    logic [15:0] w;
    if (wlog[d].size() == 0) chk("writeMissing", d, 32'hFFFF, {16'h0, a, v});
    else begin
      w = wlog[d].pop_front();
      chk("writeLog", d, 32'(w), {16'h0, a, v});
    end
  endtask

  initial begin
    rst = 1'b1; charIn = '0; charValid = 1'b0; clearReq = 1'b0; vblank = 1'b1;
    repeat (3) @(posedge pxClk);
    #2;
    chk("rstCursor", 0, 32'(curs[0]), 32'd8);
    chk("rstWe", 0, 32'(ramWe[0]), 32'd0);
    chk("rstAddr", 0, 32'(ramAddr[0]), 32'd0);
    chk("rstBusy", 2, 32'(busyO[2]), 32'd0);
    rst = 1'b0;
    tick();

    // "HI" into the 8/15 window
    flush();
    sendChar(8'h48); sendChar(8'h49); tick();
    expWrite(0, 8'd8, 8'h48); expWrite(0, 8'd9, 8'h49);
    chk("hiCursor", 0, 32'(curs[0]), 32'd10);
    chk("hiReady", 0, 32'(readyO[0]), 32'd1);

    // wrap in the 0/8 window
    sendChar(8'h0D); flush();
    for (int i = 0; i < 8; i++) sendChar(8'(8'h61 + i));
    sendChar(8'h41); tick();
    for (int i = 0; i < 8; i++) expWrite(1, 8'(i), 8'(8'h61 + i));
    expWrite(1, 8'd0, 8'h41);
    chk("wrapCursor", 1, 32'(curs[1]), 32'd1);

    // backspace and carriage return
    sendChar(8'h0D); flush();
    sendChar(8'h41); sendChar(8'h42); sendChar(8'h08); sendChar(8'h08); sendChar(8'h08); tick();
    expWrite(1, 8'd0, 8'h41); expWrite(1, 8'd1, 8'h42);
    expWrite(1, 8'd1, 8'h20); expWrite(1, 8'd0, 8'h20);
    chk("bsNoWrite", 1, 32'(wlog[1].size()), 32'd0);
    chk("bsCursor", 1, 32'(curs[1]), 32'd0);
    sendChar(8'h58); sendChar(8'h59); sendChar(8'h0D); tick();
    expWrite(1, 8'd0, 8'h58); expWrite(1, 8'd1, 8'h59);
    chk("crNoWrite", 1, 32'(wlog[1].size()), 32'd0);
    chk("crCursor", 1, 32'(curs[1]), 32'd0);

    // clear with a colliding character in the 0/6 window
    flush();
    clearReq = 1'b1; charValid = 1'b1; charIn = 8'h5A;
    #1 chk("clrBlocksReady", 2, 32'(readyO[2]), 32'd0);
    @(posedge pxClk); #2;
    clearReq = 1'b0; charValid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge pxClk);
      chk("clrBusy", 2, 32'(busyO[2]), 32'd1);
      chk("clrWe", 2, 32'(ramWe[2]), 32'd1);
      chk("clrAddr", 2, 32'(ramAddr[2]), 32'(k));
      chk("clrDin", 2, 32'(ramDin[2]), 32'h20);
    end
    @(negedge pxClk);
    chk("clrDoneBusy", 2, 32'(busyO[2]), 32'd0);
    chk("clrDoneReady", 2, 32'(readyO[2]), 32'd1);
    chk("clrDoneCursor", 2, 32'(curs[2]), 32'd0);
    repeat (12) tick();
    chk("clrCount", 2, 32'(wlog[2].size()), 32'd6);
    chk("clrCountLong", 0, 32'(wlog[0].size()), 32'd15);

    // a second request mid-sweep is ignored
    flush();
    pulseClear(); tick(); tick(); pulseClear();
    repeat (20) tick();
    chk("reqIgnored", 2, 32'(wlog[2].size()), 32'd6);
    chk("reqIgnored", 1, 32'(wlog[1].size()), 32'd8);
    chk("reqIgnored", 0, 32'(wlog[0].size()), 32'd15);

    // asynchronous reset during the third sweep write
    flush();
    pulseClear();
    @(posedge pxClk); @(posedge pxClk); #2;
    chk("preRstWe", 2, 32'(ramWe[2]), 32'd1);
    chk("preRstAddr", 2, 32'(ramAddr[2]), 32'd2);
    rst = 1'b1;
    #1;
    chk("asyncWe", 2, 32'(ramWe[2]), 32'd0);
    chk("asyncBusy", 2, 32'(busyO[2]), 32'd0);
    chk("asyncAddr", 2, 32'(ramAddr[2]), 32'd0);
    chk("abortCount", 2, 32'(wlog[2].size()), 32'd2);
    repeat (2) tick();
    rst = 1'b0; flush();
    repeat (10) tick();
    chk("postRstNoWrite", 2, 32'(wlog[2].size()), 32'd0);
    chk("postRstCursor", 2, 32'(curs[2]), 32'd0);
    chk("postRstCursor", 0, 32'(curs[0]), 32'd8);

    // vblank handling
    flush();
    vblank = 1'b0;
`ifdef LABEL_WR_VBLANK_EN
    charIn = 8'h51; charValid = 1'b1;
    repeat (3) tick();
    chk("vbReadyLow", 1, 32'(readyO[1]), 32'd0);
    chk("vbNoWrite", 1, 32'(wlog[1].size()), 32'd0);
    vblank = 1'b1;
    #1 chk("vbReadyHigh", 1, 32'(readyO[1]), 32'd1);
    @(posedge pxClk); #2;
    charValid = 1'b0;
    chk("vbWriteNext", 1, 32'(ramWe[1]), 32'd1);
    tick();
    expWrite(1, 8'd0, 8'h51);
`else
    #1 chk("vbIgnored", 1, 32'(readyO[1]), 32'd1);
    sendChar(8'h51); tick();
    expWrite(1, 8'd0, 8'h51);
`endif
    flush();
    pulseClear();
    for (int i = 0; i < 40; i++) begin
      vblank = (i % 3) != 0;
      tick();
    end
    vblank = 1'b1;
    repeat (20) tick();
    chk("vbClrCount", 2, 32'(wlog[2].size()), 32'd6);
    chk("vbClrCount", 0, 32'(wlog[0].size()), 32'd15);
    chk("vbClrBusy", 0, 32'(busyO[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
